// File: rtl/geofence_pkg.sv
// Shared types for the geofence point feeder: coordinate width, frame size,
// point record and feeder FSM states.
package geofence_pkg;

  localparam int COORD_W = 10;
  localparam int PTS     = 7;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  typedef enum logic [1:0] {
    HOLD,
    STREAM,
    WAIT
  } feeder_state_t;

endpackage

// File: rtl/geofence_point_feeder_if.sv
// Bundle of the upstream point stream, the geofence core bus and the result
// stream. The feeder uses the slave view, its environment the master view.
interface geofence_point_feeder_if;
  import geofence_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;
  logic               core_reset;
  logic [COORD_W-1:0] core_x;
  logic [COORD_W-1:0] core_y;
  logic               core_valid;
  logic               core_inside;
  logic               res_valid;
  logic               res_inside;
  logic               res_ready;
  logic               err_timeout;

  modport slave (
    input  in_valid, in_x, in_y, core_valid, core_inside, res_ready,
    output in_ready, core_reset, core_x, core_y, res_valid, res_inside, err_timeout
  );

  modport master (
    output in_valid, in_x, in_y, core_valid, core_inside, res_ready,
    input  in_ready, core_reset, core_x, core_y, res_valid, res_inside, err_timeout
  );

endinterface

// File: rtl/geofence_res_fifo.sv
// Two-entry, one-bit result FIFO with simultaneous push/pop and an
// occupancy count used by the feeder to reserve a slot before launching.
module geofence_res_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       push_data,
  input  logic       pop,
  output logic [1:0] count,
  output logic       head
);

  logic mem [2];
  logic wr_ptr;
  logic rd_ptr;
  logic push_ok;
  logic pop_ok;

  assign push_ok = push && (count != 2'd2);
  assign pop_ok  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= 1'b0;
      mem[1] <= 1'b0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/geofence_point_feeder.sv
// Buffers points into ping-pong 7-point frames, replays each frame to the
// geofence core in 7 contiguous cycles and queues the core's verdicts.
module geofence_point_feeder
  import geofence_pkg::*;
#(
  parameter int TIMEOUT = 31
) (
  input  logic                    clk,
  input  logic                    reset,
  geofence_point_feeder_if.slave  bus
);

  localparam int         CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [2:0] LAST_IDX = 3'(PTS - 1);

  point_t             bank [2][PTS];
  logic [1:0]         bank_full;
  logic               wr_bank;
  logic               rd_bank;
  logic [2:0]         wr_idx;
  logic [2:0]         rd_idx;
  feeder_state_t      state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               core_reset;
  logic [COORD_W-1:0] core_x;
  logic [COORD_W-1:0] core_y;
  logic               err_timeout;

  logic               wr_fire;
  logic               push;
  logic               pop;
  logic [1:0]         res_count;
  logic               res_head;
  logic [2:0]         occ_next;
  logic               launch_ok;
  point_t             first_point;
  point_t             next_point;

  assign bus.in_ready    = !bank_full[wr_bank];
  assign bus.core_reset  = core_reset;
  assign bus.core_x      = core_x;
  assign bus.core_y      = core_y;
  assign bus.res_valid   = (res_count != 2'd0);
  assign bus.res_inside  = res_head;
  assign bus.err_timeout = err_timeout;

  assign wr_fire     = bus.in_valid && !bank_full[wr_bank];
  // The core's valid survives its own reset, so it only counts while waiting.
  assign push        = (state == WAIT) && bus.core_valid;
  assign pop         = bus.res_valid && bus.res_ready;
  assign occ_next    = {1'b0, res_count} + {2'b0, push} - {2'b0, pop};
  // Launch only if a slot stays free for the frame being launched.
  assign launch_ok   = bank_full[rd_bank] && (occ_next <= 3'd1);
  assign first_point = bank[rd_bank][0];
  assign next_point  = bank[rd_bank][rd_idx];

  geofence_res_fifo u_res_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.core_inside),
    .pop       (pop),
    .count     (res_count),
    .head      (res_head)
  );

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank[wr_bank][wr_idx] <= point_t'{x: bus.in_x, y: bus.in_y};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HOLD;
      bank_full   <= 2'b00;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_idx      <= 3'd0;
      rd_idx      <= 3'd0;
      wait_cnt    <= '0;
      core_reset  <= 1'b1;
      core_x      <= '0;
      core_y      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_idx == LAST_IDX) begin
          bank_full[wr_bank] <= 1'b1;
          wr_bank            <= ~wr_bank;
          wr_idx             <= 3'd0;
        end else begin
          wr_idx <= wr_idx + 3'd1;
        end
      end

      case (state)
        HOLD: begin
          core_reset <= 1'b1;
          if (launch_ok) begin
            core_reset <= 1'b0;
            core_x     <= first_point.x;
            core_y     <= first_point.y;
            rd_idx     <= 3'd1;
            state      <= STREAM;
          end
        end

        STREAM: begin
          core_x <= next_point.x;
          core_y <= next_point.y;
          if (rd_idx == LAST_IDX) begin
            bank_full[rd_bank] <= 1'b0;
            rd_bank            <= ~rd_bank;
            wait_cnt           <= '0;
            state              <= WAIT;
          end else begin
            rd_idx <= rd_idx + 3'd1;
          end
        end

        WAIT: begin
          if (bus.core_valid) begin
            if (launch_ok) begin
              core_x <= first_point.x;
              core_y <= first_point.y;
              rd_idx <= 3'd1;
              state  <= STREAM;
            end else begin
              core_reset <= 1'b1;
              state      <= HOLD;
            end
          end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
            err_timeout <= 1'b1;
            core_reset  <= 1'b1;
            state       <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          core_reset <= 1'b1;
          state      <= HOLD;
        end
      endcase
    end
  end

endmodule
